// File: rtl/stack_ptr_unit_pkg.sv
// Package for the stack pointer unit.
// Holds the address width, the default stack bases/depths, the per-stack
// occupancy state enum, and a helper that computes the empty-stack pointer.
package jala_stack_pkg;

  localparam int AW = 16;

  localparam logic [AW-1:0] MS_BASE_DEF  = 16'h7FFF;
  localparam int            MS_DEPTH_DEF = 256;
  localparam logic [AW-1:0] RS_BASE_DEF  = 16'h1FFF;
  localparam int            RS_DEPTH_DEF = 64;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } stk_state_e;

  // An empty stack points one word above its base (wraps modulo 2^AW).
  function automatic logic [AW-1:0] empty_ptr(input logic [AW-1:0] base);
    return base + 16'd1;
  endfunction

endpackage

// File: rtl/stack_ptr_unit_if.sv
// Command/status bundle between the control FSM and the stack pointer unit.
//   master: control side (drives the push/pop/reload commands, reads pointers)
//   slave : stack pointer unit (reads commands, drives pointers/depths/faults)
interface stack_ptr_unit_if;
  import jala_stack_pkg::*;

  logic          MSPop;
  logic          MSPWrite;
  logic          MSPRegReset;
  logic          RSPop;
  logic          RSPWrite;
  logic          RSPRegReset;

  logic [AW-1:0] MSP;
  logic [AW-1:0] MSPNext;
  logic [AW-1:0] RSP;
  logic [AW-1:0] MSDepth;
  logic [AW-1:0] RSDepth;
  logic          MSOverflow;
  logic          MSUnderflow;
  logic          RSOverflow;
  logic          RSUnderflow;
  logic          StackFault;

  modport master (
    output MSPop, MSPWrite, MSPRegReset, RSPop, RSPWrite, RSPRegReset,
    input  MSP, MSPNext, RSP, MSDepth, RSDepth,
    input  MSOverflow, MSUnderflow, RSOverflow, RSUnderflow, StackFault
  );

  modport slave (
    input  MSPop, MSPWrite, MSPRegReset, RSPop, RSPWrite, RSPRegReset,
    output MSP, MSPNext, RSP, MSDepth, RSDepth,
    output MSOverflow, MSUnderflow, RSOverflow, RSUnderflow, StackFault
  );

endinterface

// File: rtl/stack_ptr_unit_ch.sv
// One stack channel: pointer, depth counter, EMPTY/PARTIAL/FULL state machine
// and a sticky overflow/underflow pair.
//   clk, rst_n     : clock, asynchronous active-low reset
//   pop_i          : 1 = pop, 0 = push (used only with write_i)
//   write_i        : apply a command this cycle
//   reg_reset_i    : synchronous reload to empty, clears faults (beats write_i)
//   ptr_o, depth_o : top-of-stack address and number of valid words
//   ovf_o, unf_o   : sticky overflow / underflow
module stack_ptr_ch
  import jala_stack_pkg::*;
#(
  parameter logic [AW-1:0] BASE  = MS_BASE_DEF,
  parameter int            DEPTH = MS_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pop_i,
  input  logic          write_i,
  input  logic          reg_reset_i,
  output logic [AW-1:0] ptr_o,
  output logic [AW-1:0] depth_o,
  output logic          ovf_o,
  output logic          unf_o
);

  localparam logic [AW-1:0] PTR_EMPTY = empty_ptr(BASE);
  // Depth carries one extra bit so a capacity of 2^AW words is representable.
  localparam logic [AW:0]   DEPTH_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_D     = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_P     = AW'(1);

  stk_state_e    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  // Low on the first edge after reset release so that edge's command is dropped.
  logic          armed_q;

  // State, pointer, depth, fault and arm registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= PTR_EMPTY;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      armed_q <= 1'b1;
    end
  end

  // Next-state logic: reload beats write; full push / empty pop only set a flag.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (!armed_q) begin
      state_d = state_q;
    end else if (reg_reset_i) begin
      state_d = EMPTY;
      ptr_d   = PTR_EMPTY;
      depth_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (write_i) begin
      if (pop_i) begin
        case (state_q)
          EMPTY: begin
            unf_d = 1'b1;
          end
          PARTIAL, FULL: begin
            ptr_d   = ptr_q + ONE_P;
            depth_d = depth_q - ONE_D;
            if (depth_q == ONE_D) begin
              state_d = EMPTY;
            end else begin
              state_d = PARTIAL;
            end
          end
          default: begin
            state_d = EMPTY;
            ptr_d   = PTR_EMPTY;
            depth_d = '0;
          end
        endcase
      end else begin
        case (state_q)
          FULL: begin
            ovf_d = 1'b1;
          end
          EMPTY, PARTIAL: begin
            ptr_d   = ptr_q - ONE_P;
            depth_d = depth_q + ONE_D;
            if ((depth_q + ONE_D) == DEPTH_MAX) begin
              state_d = FULL;
            end else begin
              state_d = PARTIAL;
            end
          end
          default: begin
            state_d = EMPTY;
            ptr_d   = PTR_EMPTY;
            depth_d = '0;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  assign ptr_o   = ptr_q;
  assign depth_o = depth_q[AW-1:0];
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

endmodule

// File: rtl/stack_ptr_unit.sv
// Main-stack and return-stack pointer unit answering the control FSM's
// push/pop/reload commands, with bounds checking and sticky fault flags.
//   clk    : system clock
//   rst    : asynchronous active-low reset
//   bus_if : slave side of stack_ptr_unit_if (commands in; MSP, MSPNext, RSP,
//            depths, four fault flags and their OR out)
module stack_ptr_unit
  import jala_stack_pkg::*;
#(
  parameter logic [AW-1:0] MS_BASE  = MS_BASE_DEF,
  parameter int            MS_DEPTH = MS_DEPTH_DEF,
  parameter logic [AW-1:0] RS_BASE  = RS_BASE_DEF,
  parameter int            RS_DEPTH = RS_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  stack_ptr_unit_if.slave  bus_if
);

  logic [AW-1:0] msp_s;
  logic [AW-1:0] ms_depth_s;
  logic          ms_ovf_s;
  logic          ms_unf_s;
  logic [AW-1:0] rsp_s;
  logic [AW-1:0] rs_depth_s;
  logic          rs_ovf_s;
  logic          rs_unf_s;

  stack_ptr_ch #(.BASE(MS_BASE), .DEPTH(MS_DEPTH)) u_ms (
    .clk         (clk),
    .rst_n       (rst),
    .pop_i       (bus_if.MSPop),
    .write_i     (bus_if.MSPWrite),
    .reg_reset_i (bus_if.MSPRegReset),
    .ptr_o       (msp_s),
    .depth_o     (ms_depth_s),
    .ovf_o       (ms_ovf_s),
    .unf_o       (ms_unf_s)
  );

  stack_ptr_ch #(.BASE(RS_BASE), .DEPTH(RS_DEPTH)) u_rs (
    .clk         (clk),
    .rst_n       (rst),
    .pop_i       (bus_if.RSPop),
    .write_i     (bus_if.RSPWrite),
    .reg_reset_i (bus_if.RSPRegReset),
    .ptr_o       (rsp_s),
    .depth_o     (rs_depth_s),
    .ovf_o       (rs_ovf_s),
    .unf_o       (rs_unf_s)
  );

  assign bus_if.MSP         = msp_s;
  // Second element address; meaningless below depth 2 but always MSP+1.
  assign bus_if.MSPNext     = msp_s + AW'(1);
  assign bus_if.RSP         = rsp_s;
  assign bus_if.MSDepth     = ms_depth_s;
  assign bus_if.RSDepth     = rs_depth_s;
  assign bus_if.MSOverflow  = ms_ovf_s;
  assign bus_if.MSUnderflow = ms_unf_s;
  assign bus_if.RSOverflow  = rs_ovf_s;
  assign bus_if.RSUnderflow = rs_unf_s;
  assign bus_if.StackFault  = ms_ovf_s | ms_unf_s | rs_ovf_s | rs_unf_s;

endmodule

// File: tb/tb_stack_ptr_unit.sv
// Self-checking bench for stack_ptr_unit: directed scenarios followed by
// randomized commands, all compared against a word-count model of each stack.
module tb_stack_ptr_unit;
  import jala_stack_pkg::*;

  localparam logic [15:0] MSB = 16'h7FFF;
  localparam int          MSD = 256;
  localparam logic [15:0] RSB = 16'h1FFF;
  localparam int          RSD = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stack_ptr_unit_if bus();

  stack_ptr_unit #(.MS_BASE(MSB), .MS_DEPTH(MSD), .RS_BASE(RSB), .RS_DEPTH(RSD)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: each stack is just a count of valid words plus flags.
  int m_cnt, r_cnt;
  bit m_ov, m_un, r_ov, r_un;
  bit armed;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ptr_of(input logic [15:0] base, input int cnt);
    logic [31:0] v;
    v = 32'(base) + 32'd1 - 32'(cnt);
    return v[15:0];
  endfunction

  task automatic model_reset();
    m_cnt = 0; r_cnt = 0;
    m_ov = 1'b0; m_un = 1'b0; r_ov = 1'b0; r_un = 1'b0;
    armed = 1'b0;
  endtask

  task automatic model_cmd(input bit pop, input bit wr, input bit rr, input int cap,
                           inout int cnt, inout bit ov, inout bit un);
    if (rr) begin
      cnt = 0; ov = 1'b0; un = 1'b0;
    end else if (wr) begin
      if (pop) begin
        if (cnt == 0) un = 1'b1;
        else cnt--;
      end else begin
        if (cnt == cap) ov = 1'b1;
        else cnt++;
      end
    end
  endtask

  task automatic check_all(input string ph);
    logic [15:0] e_msp;
    e_msp = ptr_of(MSB, m_cnt);
    chk({ph, " MSP"},         32'(bus.MSP),         32'(e_msp));
    chk({ph, " MSPNext"},     32'(bus.MSPNext),     32'(16'(e_msp + 16'd1)));
    chk({ph, " RSP"},         32'(bus.RSP),         32'(ptr_of(RSB, r_cnt)));
    chk({ph, " MSDepth"},     32'(bus.MSDepth),     32'(m_cnt));
    chk({ph, " RSDepth"},     32'(bus.RSDepth),     32'(r_cnt));
    chk({ph, " MSOverflow"},  32'(bus.MSOverflow),  32'(m_ov));
    chk({ph, " MSUnderflow"}, 32'(bus.MSUnderflow), 32'(m_un));
    chk({ph, " RSOverflow"},  32'(bus.RSOverflow),  32'(r_ov));
    chk({ph, " RSUnderflow"}, 32'(bus.RSUnderflow), 32'(r_un));
    chk({ph, " StackFault"},  32'(bus.StackFault),  32'(m_ov | m_un | r_ov | r_un));
  endtask

  // Called just after a falling edge; applies one cycle of commands.
  task automatic step(input string ph, input bit mp, input bit mw, input bit mr,
                      input bit rp, input bit rw, input bit rr);
    bus.MSPop = mp; bus.MSPWrite = mw; bus.MSPRegReset = mr;
    bus.RSPop = rp; bus.RSPWrite = rw; bus.RSPRegReset = rr;
    @(posedge clk);
    if (!armed) begin
      armed = 1'b1;
    end else begin
      model_cmd(mp, mw, mr, MSD, m_cnt, m_ov, m_un);
      model_cmd(rp, rw, rr, RSD, r_cnt, r_ov, r_un);
    end
    #1;
    check_all(ph);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    bus.MSPop = 1'b0; bus.MSPWrite = 1'b0; bus.MSPRegReset = 1'b0;
    bus.RSPop = 1'b0; bus.RSPWrite = 1'b0; bus.RSPRegReset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;
    step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Three main-stack pushes.
    for (int i = 0; i < 3; i++) step("ms_push3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp1 MSP", 32'(bus.MSP), 32'h7FFD);
    chk("tp1 MSDepth", 32'(bus.MSDepth), 32'd3);
    chk("tp1 MSPNext", 32'(bus.MSPNext), 32'h7FFE);

    // Pop from an empty return stack, then reload it.
    step("rs_unf", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("tp2 RSP", 32'(bus.RSP), 32'h2000);
    chk("tp2 RSUnderflow", 32'(bus.RSUnderflow), 32'd1);
    chk("tp2 StackFault", 32'(bus.StackFault), 32'd1);
    step("rs_reload", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("tp2 RSUnderflow clr", 32'(bus.RSUnderflow), 32'd0);

    // Fill the main stack, push once more, then pop once.
    step("ms_reload", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < MSD + 1; i++) step("ms_fill", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp3 MSP", 32'(bus.MSP), 32'h7F00);
    chk("tp3 MSDepth", 32'(bus.MSDepth), 32'd256);
    chk("tp3 MSOverflow", 32'(bus.MSOverflow), 32'd1);
    step("ms_pop_full", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp3 MSP pop", 32'(bus.MSP), 32'h7F01);
    chk("tp3 MSOverflow sticky", 32'(bus.MSOverflow), 32'd1);

    // Simultaneous pushes on both stacks from empty.
    step("both_reload", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("jpush", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("tp4 MSP", 32'(bus.MSP), 32'h7FFF);
    chk("tp4 RSP", 32'(bus.RSP), 32'h1FFF);

    // Reload wins over a simultaneous write at depth 5.
    for (int i = 0; i < 4; i++) step("ms_push5", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp5 MSDepth pre", 32'(bus.MSDepth), 32'd5);
    step("reload_vs_write", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("tp5 MSP", 32'(bus.MSP), 32'h8000);
    chk("tp5 MSDepth", 32'(bus.MSDepth), 32'd0);

    // Asynchronous reset between edges at depth 10.
    for (int i = 0; i < 10; i++) step("ms_push10", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp6 MSDepth pre", 32'(bus.MSDepth), 32'd10);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    @(negedge clk);
    rst = 1'b1;
    step("release_edge", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("tp6 MSP release", 32'(bus.MSP), 32'h8000);
    step("post_rst_push", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp6 MSP push", 32'(bus.MSP), 32'h7FFF);

    // Randomized phases with shifting push/pop bias.
    for (int seg = 0; seg < 10; seg++) begin
      int m_pop_pct, r_pop_pct;
      m_pop_pct = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 90);
      r_pop_pct = (seg % 2 == 0) ? 15 : 85;
      for (int c = 0; c < 500; c++) begin
        bit mp, mw, mr, rp, rw, rr;
        mw = ($urandom_range(0, 3) != 0);
        mp = ($urandom_range(0, 99) < m_pop_pct);
        mr = ($urandom_range(0, 299) == 0);
        rw = ($urandom_range(0, 2) != 0);
        rp = ($urandom_range(0, 99) < r_pop_pct);
        rr = ($urandom_range(0, 299) == 0);
        step("rand", mp, mw, mr, rp, rw, rr);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
